// File: rtl/coyote_pad_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : coyote_pad_tx_arb
// Description : Round-robin arbiter between two wide sources (A, B) feeding a
//               single narrow pad lane. A granted word is sent as one header
//               beat {src, beat_count} followed by LSB-first data beats, with a
//               valid/yumi handshake on the pad side.
// Revision    : 1.0 - initial release
// ============================================================================
module coyote_pad_tx_arb #(
  parameter int A_W    = 16,
  parameter int B_W    = 80,
  parameter int LANE_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              a_v_i,
  input  logic [A_W-1:0]    a_data_i,
  output logic              a_ready_o,
  input  logic              b_v_i,
  input  logic [B_W-1:0]    b_data_i,
  output logic              b_ready_o,
  output logic              pad_v_o,
  output logic [LANE_W-1:0] pad_data_o,
  output logic              pad_last_o,
  output logic              pad_src_o,
  input  logic              pad_yumi_i
);

  localparam int CNT_W = LANE_W - 1;
  localparam logic [CNT_W-1:0] NA = CNT_W'(A_W / LANE_W);
  localparam logic [CNT_W-1:0] NB = CNT_W'(B_W / LANE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [B_W-1:0]    word;
  logic [CNT_W-1:0]  k;
  logic              last_src;

  logic              grant_a;
  logic              grant_b;
  logic              accept;
  logic [CNT_W-1:0]  n_beats;
  logic [CNT_W-1:0]  n_last;
  logic              k_last;

  // Beat count of the packet currently in flight (pad_src_o holds its source)
  always_comb begin
    n_beats = pad_src_o ? NB : NA;
    n_last  = n_beats - CNT_W'(1);
    k_last  = (k == n_last);
  end

  // Arbitration, ready generation and next-state selection
  always_comb begin
    state_nxt = state;
    grant_b   = 1'b0;
    grant_a   = 1'b0;
    a_ready_o = 1'b0;
    b_ready_o = 1'b0;
    accept    = 1'b0;
    // On a tie, serve the source that was not served last
    if (a_v_i && b_v_i) begin
      grant_b = ~last_src;
    end else begin
      grant_b = b_v_i;
    end
    grant_a = a_v_i & ~grant_b;
    case (state)
      IDLE: begin
        // reset_i gating keeps both readies low while reset is asserted
        a_ready_o = reset_i & en_i & grant_a;
        b_ready_o = reset_i & en_i & grant_b;
        accept    = a_ready_o | b_ready_o;
        if (accept) begin
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (pad_yumi_i) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (pad_yumi_i && k_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word latch, beat shifting, beat counter and registered pad outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      word       <= '0;
      k          <= '0;
      last_src   <= 1'b1;
      pad_v_o    <= 1'b0;
      pad_data_o <= '0;
      pad_last_o <= 1'b0;
      pad_src_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word       <= b_ready_o ? b_data_i : B_W'(a_data_i);
            pad_src_o  <= b_ready_o;
            pad_v_o    <= 1'b1;
            pad_data_o <= {b_ready_o, (b_ready_o ? NB : NA)};
            pad_last_o <= 1'b0;
            k          <= '0;
          end
        end
        HDR: begin
          if (pad_yumi_i) begin
            pad_data_o <= word[LANE_W-1:0];
            word       <= word >> LANE_W;
            k          <= '0;
            pad_last_o <= (n_last == '0);
          end
        end
        DATA: begin
          if (pad_yumi_i) begin
            if (!k_last) begin
              k          <= k + CNT_W'(1);
              pad_data_o <= word[LANE_W-1:0];
              word       <= word >> LANE_W;
              pad_last_o <= ((k + CNT_W'(1)) == n_last);
            end else begin
              // Packet complete: release the lane and advance the pointer
              pad_v_o    <= 1'b0;
              pad_data_o <= '0;
              pad_last_o <= 1'b0;
              k          <= '0;
              last_src   <= pad_src_o;
            end
          end
        end
        default: begin
          pad_v_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coyote_pad_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_coyote_pad_tx_arb
// Description : Scoreboard bench for coyote_pad_tx_arb. Stimulus pushes the
//               expected beats of each packet; a monitor pops and compares
//               every beat the pad side consumes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coyote_pad_tx_arb;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic        a_v_i;
  logic [15:0] a_data_i;
  logic        a_ready_o;
  logic        b_v_i;
  logic [79:0] b_data_i;
  logic        b_ready_o;
  logic        pad_v_o;
  logic [7:0]  pad_data_o;
  logic        pad_last_o;
  logic        pad_src_o;
  logic        pad_yumi_i;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       src;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    yumi_mode = 0;   // 0: always 1, 1: toggle every cycle

  coyote_pad_tx_arb dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .a_v_i      (a_v_i),
    .a_data_i   (a_data_i),
    .a_ready_o  (a_ready_o),
    .b_v_i      (b_v_i),
    .b_data_i   (b_data_i),
    .b_ready_o  (b_ready_o),
    .pad_v_o    (pad_v_o),
    .pad_data_o (pad_data_o),
    .pad_last_o (pad_last_o),
    .pad_src_o  (pad_src_o),
    .pad_yumi_i (pad_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected packet: header {src, n} then n LSB-first data bytes
  task automatic push_pkt(input logic src, input logic [79:0] w, input int n);
    beat_t b;
    b.d = {src, 7'(n)}; b.last = 1'b0; b.src = src;
    exp_q.push_back(b);
    for (int i = 0; i < n; i++) begin
      b.d    = w[i*8 +: 8];
      b.last = (i == n - 1);
      b.src  = src;
      exp_q.push_back(b);
    end
  endtask

  // Present one word on a source until it is accepted, then withdraw it
  task automatic issue(input logic src, input logic [79:0] w);
    int guard = 0;
    push_pkt(src, w, src ? 10 : 2);
    if (src) begin b_data_i = w; b_v_i = 1'b1; end
    else begin a_data_i = w[15:0]; a_v_i = 1'b1; end
    do begin
      @(negedge clk_i);
      guard++;
    end while (!(src ? b_ready_o : a_ready_o) && guard < 80);
    if (guard >= 80) chk("accept_timeout", 1, 0);
    @(posedge clk_i); #1;
    a_v_i = 1'b0;
    b_v_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    do begin
      @(negedge clk_i);
      guard++;
    end while ((exp_q.size() != 0 || pad_v_o) && guard < 200);
    chk(name, exp_q.size(), 0);
    @(posedge clk_i); #1;
  endtask

  // Pad-side yumi driver
  initial begin
    pad_yumi_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      if (yumi_mode == 1) pad_yumi_i = ~pad_yumi_i;
      else                pad_yumi_i = 1'b1;
    end
  end

  // Monitor: compare every consumed beat, and check held beats stay stable
  initial begin
    logic       held = 1'b0;
    logic [9:0] held_val = '0;
    beat_t      e;
    forever begin
      @(negedge clk_i);
      if (reset_i && pad_v_o) begin
        if (held) chk("hold_stable", {pad_data_o, pad_last_o, pad_src_o}, held_val);
        held     = !pad_yumi_i;
        held_val = {pad_data_o, pad_last_o, pad_src_o};
        if (pad_yumi_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {pad_data_o, pad_last_o, pad_src_o}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {pad_data_o, pad_last_o, pad_src_o}, {e.d, e.last, e.src});
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Directed stimulus
  initial begin
    int n;
    int guard;
    int acc[2];
    logic prev_rdy;

    // Reset with every input high
    reset_i  = 1'b0;
    en_i     = 1'b1;
    a_v_i    = 1'b1;
    b_v_i    = 1'b1;
    a_data_i = 16'h1234;
    b_data_i = 80'hA1A2_A3A4_A5A6_A7A8_A9AA;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_pad", {pad_v_o, pad_data_o, pad_last_o, pad_src_o}, 0);
    chk("rst_ready", {a_ready_o, b_ready_o}, 0);

    // Both held valid for three packets: A, B, A
    push_pkt(1'b0, 80'h1234, 2);
    push_pkt(1'b1, 80'hA1A2_A3A4_A5A6_A7A8_A9AA, 10);
    push_pkt(1'b0, 80'h1234, 2);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    n = 0; guard = 0;
    while (n < 3 && guard < 100) begin
      @(negedge clk_i);
      guard++;
      if (guard == 1) chk("ready_after_rst", {a_ready_o, b_ready_o}, 2'b10);
      if (a_ready_o || b_ready_o) n++;
    end
    chk("tie_accepts", n, 3);
    @(posedge clk_i); #1;
    a_v_i = 1'b0;
    b_v_i = 1'b0;
    drain("drain_tie");

    // A only, BEEF held valid: 1-cycle ready pulse, header next cycle, 4-cycle spacing
    push_pkt(1'b0, 80'hBEEF, 2);
    push_pkt(1'b0, 80'hBEEF, 2);
    a_data_i = 16'hBEEF;
    a_v_i    = 1'b1;
    n = 0; guard = 0; prev_rdy = 1'b0;
    while (n < 2 && guard < 40) begin
      @(negedge clk_i);
      guard++;
      if (prev_rdy) chk("a_pulse_hdr", {a_ready_o, pad_v_o, pad_data_o}, {1'b0, 1'b1, 8'h02});
      prev_rdy = a_ready_o;
      if (a_ready_o) begin acc[n] = cyc; n++; end
    end
    @(posedge clk_i); #1;
    a_v_i = 1'b0;
    chk("a_accept_spacing", acc[1] - acc[0], 4);
    @(negedge clk_i);
    chk("a_pulse_hdr2", {a_ready_o, pad_v_o, pad_data_o}, {1'b0, 1'b1, 8'h02});
    drain("drain_a");

    // B only, yumi toggling
    yumi_mode = 1;
    issue(1'b1, 80'h0102_0304_0506_0708_090A);
    drain("drain_b");
    yumi_mode = 0;

    // Reset pulsed during B data beat 4
    issue(1'b1, 80'h0102_0304_0506_0708_090A);
    guard = 0;
    do begin
      @(posedge clk_i); #2;
      guard++;
    end while (!(pad_v_o && pad_data_o == 8'h06) && guard < 40);
    chk("reach_beat4", (guard < 40), 1);
    reset_i = 1'b0;
    #1;
    chk("async_drop", {pad_v_o, pad_last_o, pad_data_o}, 0);
    exp_q.delete();
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    issue(1'b1, 80'h0102_0304_0506_0708_090A);
    drain("drain_after_rst");

    // en low blocks grants
    en_i     = 1'b0;
    a_data_i = 16'h5A5A;
    a_v_i    = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("en_block", {a_ready_o, pad_v_o}, 0);
    end
    @(posedge clk_i); #1;
    a_v_i = 1'b0;

    // en dropped mid-packet: packet completes, then no grants
    en_i = 1'b1;
    issue(1'b0, 80'hC3D4);
    en_i  = 1'b0;
    a_v_i = 1'b1;
    repeat (7) begin
      @(negedge clk_i);
      chk("en_low_no_grant", a_ready_o, 0);
    end
    chk("en_low_pkt_done", {exp_q.size() == 0, pad_v_o}, 2'b10);
    @(posedge clk_i); #1;
    a_v_i = 1'b0;
    en_i  = 1'b1;
    issue(1'b0, 80'h7788);
    drain("drain_en");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/coyote_pad_tx_arb.md
# coyote_pad_tx_arb

Round-robin arbiter and serializer that shares one narrow output pad lane between two wide on-chip sources in the coyote test chip. Source A is the RoCC command word (16 bits) and source B is the FSB node output packet (80 bits). The block grants one source at a time, latches its word and sends it over the pad lane as one header beat followed by LSB-first data beats, with a valid/yumi handshake toward the pad side. It sits between the bsg_rocket_node_client_rocc outputs and the output pad ring, so a small number of pads can carry traffic that would otherwise need one pad per bit.

## Interface

Parameters:
- A_W, 16, source A word width; must be a multiple of LANE_W.
- B_W, 80, source B word width; must be a multiple of LANE_W.
- LANE_W, 8, pad lane width. The beat count of either source must fit in LANE_W-1 bits.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_i  in  1  reset; asynchronous, active-low.
- en_i  in  1  allows new grants; an in-flight packet always completes.
- a_v_i  in  1  source A word valid.
- a_data_i  in  A_W  source A word.
- a_ready_o  out  1  source A word accepted when a_v_i & a_ready_o.
- b_v_i  in  1  source B word valid.
- b_data_i  in  B_W  source B word.
- b_ready_o  out  1  source B word accepted when b_v_i & b_ready_o.
- pad_v_o  out  1  pad beat valid.
- pad_data_o  out  LANE_W  pad beat.
- pad_last_o  out  1  marks the final data beat of a packet.
- pad_src_o  out  1  source of the current packet: 0 = A, 1 = B.
- pad_yumi_i  in  1  the pad side consumed the current beat; only meaningful while pad_v_o = 1.

## Operation

- Beat counts: NA = A_W/LANE_W, NB = B_W/LANE_W. With default parameters, NA = 2 and NB = 10.
- The FSM has three states: IDLE, HDR and DATA.
- IDLE:
  - Grant goes to the single valid source. If both sources are valid, grant goes to the source that was not served last.
  - The last_src register resets to B, so A wins the first tie after reset.
  - a_ready_o / b_ready_o equal the grant, gated by en_i. These are combinational outputs; at most one is high.
  - On accept, the word is latched into a B_W shift register (A is zero-extended), pad_src_o is set, and the FSM goes to HDR.
- HDR:
  - pad_v_o = 1.
  - pad_data_o[LANE_W-1] = source bit; pad_data_o[LANE_W-2:0] = beat count N (NA or NB).
  - On pad_yumi_i, go to DATA and set beat counter = 0.
- DATA:
  - pad_v_o = 1.
  - pad_data_o = word[k*LANE_W +: LANE_W] for beat k.
  - pad_last_o = 1 when k = N-1.
  - On pad_yumi_i: if k < N-1, increment k; else load last_src with the packet's source and return to IDLE.
- Without pad_yumi_i, the current beat, pad_src_o and pad_last_o stay stable.
- pad_yumi_i while pad_v_o = 0 is ignored.
- Both ready outputs are 0 outside IDLE. Source inputs are don't-care outside the accept cycle.
- Reset values: FSM = IDLE, pad_v_o = 0, pad_data_o = 0, pad_last_o = 0, pad_src_o = 0, last_src = B, k = 0. Both ready outputs are forced to 0 while reset_i = 0.
- Reset asserted mid-packet: all state clears immediately and the partial packet is dropped with no trailing beats. The pad side must discard a packet that has no pad_last_o.
- en_i low in HDR or DATA has no effect. en_i low in IDLE blocks grants, and the priority pointer is unchanged.

## Timing

- Accept in cycle t → header valid in t+1.
- With pad_yumi_i held high: data beats in t+2 .. t+1+N, pad_last_o in t+1+N, IDLE in t+2+N. A new accept is possible in t+2+N.
- Throughput: one packet per N+2 cycles. A packet is 4 cycles, a B packet is 12 cycles.
- Each cycle with pad_yumi_i low while pad_v_o = 1 adds exactly one cycle.
- Ready is combinational from the valid inputs, en_i and registered state. The pad outputs are registered.

## Test plan

- Reset with all inputs high → all pad outputs 0 and both ready outputs 0; after release, a_ready_o = 1 in the same cycle.
- A only: a_data_i = 16'hBEEF, yumi held at 1 → beats 0x02, 0xEF, 0xBE; pad_last_o on 0xBE; pad_src_o = 0; a_ready_o is a 1-cycle pulse; next accept 4 cycles later.
- B only: b_data_i = 80'h0102_0304_0506_0708_090A, yumi low on every other cycle → header 0x8A, then 0x0A, 0x09, … 0x01, each beat held until yumi; 10 data beats; pad_last_o only on 0x01.
- Both sources held valid for three packets after reset → served in order A, B, A; pad_src_o = 0, 1, 0.
- reset_i pulsed low during B beat 4 → pad_v_o drops asynchronously; after release, the first beat from a fresh B request is a header 0x8A.
- en_i = 0 with A valid → no grant; en_i dropped during an A packet → the packet completes, then there are no further grants until en_i = 1.
